toggle_activity_counter: RTL and testbench

//  Downstream consumer of gate-level DUT nets (e.g. mux2x1 a/b/sel/out) in the power-estimation flow.

---
 rtl/pwr_est_pkg.sv | 20 ++
 rtl/toggle_cell.sv | 41 ++++
 rtl/toggle_activity_counter.sv | 143 ++++++++++++++
 tb/tb_toggle_activity_counter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwr_est_pkg.sv
// Shared types and helpers for the power-estimation toggle counter.
//   state_e : measurement FSM states (idle, arm, count, drain)
//   sat_inc : increment that holds at the all-ones value of a given width
package pwr_est_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StCount,
    StDrain
  } state_e;

  // Widths up to 32 bits are supported; callers zero-extend into 32 bits and truncate back.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = 32'hFFFF_FFFF >> (32 - width);
    return (val == max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/toggle_cell.sv
// One monitored net: keeps the previous sample and a saturating transition counter.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears prev and count)
//   clr    synchronous counter clear
//   en     count transitions of d against the previous sample this cycle
//   d      monitored net
//   cnt    current toggle count
module toggle_cell #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             d,
  output logic [CNT_W-1:0] cnt
);
  import pwr_est_pkg::*;

  logic             prev_q;
  logic [CNT_W-1:0] cnt_q;

  // prev tracks d every cycle, so the cycle before counting starts provides the baseline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prev_q <= d;
      if (clr) begin
        cnt_q <= '0;
      end else if (en && (d != prev_q)) begin
        cnt_q <= CNT_W'(sat_inc(32'(cnt_q), CNT_W));
      end
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/toggle_activity_counter.sv
// Counts 0->1 / 1->0 transitions on NUM_SIG nets over a programmable window, then streams the
// per-net counts out over a valid/ready handshake, one net per beat.
// Optional feature macro: TOGGLE_TOTAL_EN adds res_total (sum of all counts, on the last beat).
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   start             one-cycle pulse starting a measurement (ignored while busy)
//   window_len        number of counting cycles, captured on an accepted start
//   sig_in            monitored nets
//   busy              accepted start until the last result beat is taken
//   res_valid/ready   result handshake
//   res_idx           net index of the current beat
//   res_count         toggle count of net res_idx
//   res_last          current beat is the final net
//   done              one-cycle pulse after the final beat transfers
//   res_total         (TOGGLE_TOTAL_EN only) sum of counts on the last beat, else 0
module toggle_activity_counter #(
  parameter int unsigned NUM_SIG = 4,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned WIN_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [WIN_W-1:0]           window_len,
  input  logic [NUM_SIG-1:0]         sig_in,
  output logic                       busy,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [$clog2(NUM_SIG)-1:0] res_idx,
  output logic [CNT_W-1:0]           res_count,
  output logic                       res_last,
`ifdef TOGGLE_TOTAL_EN
  output logic [CNT_W+$clog2(NUM_SIG)-1:0] res_total,
`endif
  output logic                       done
);
  import pwr_est_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_SIG);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_SIG - 1);

  state_e           state_q;
  logic [WIN_W-1:0] win_q;
  logic [IDX_W-1:0] idx_q;
  logic             busy_q;
  logic             valid_q;
  logic             done_q;

  logic             clr;
  logic             en;
  logic [CNT_W-1:0] cnt [NUM_SIG];

  assign clr = (state_q == StIdle) && start;
  assign en  = (state_q == StCount);

  for (genvar g = 0; g < NUM_SIG; g++) begin : g_cell
    toggle_cell #(
      .CNT_W(CNT_W)
    ) u_cell (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clr),
      .en   (en),
      .d    (sig_in[g]),
      .cnt  (cnt[g])
    );
  end

  // win_q counts remaining samples; the cycle holding 1 takes the last sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      win_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            win_q   <= window_len;
            busy_q  <= 1'b1;
            state_q <= StArm;
          end
        end
        StArm: begin
          if (win_q == '0) begin
            state_q <= StDrain;
            valid_q <= 1'b1;
          end else begin
            state_q <= StCount;
          end
        end
        StCount: begin
          win_q <= win_q - WIN_W'(1);
          if (win_q == WIN_W'(1)) begin
            state_q <= StDrain;
            valid_q <= 1'b1;
          end
        end
        StDrain: begin
          if (res_ready) begin
            if (idx_q == LastIdx) begin
              idx_q   <= '0;
              state_q <= StIdle;
              busy_q  <= 1'b0;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = busy_q;
  assign res_valid = valid_q;
  assign res_idx   = idx_q;
  assign res_last  = valid_q && (idx_q == LastIdx);
  assign res_count = valid_q ? cnt[idx_q] : '0;
  assign done      = done_q;

`ifdef TOGGLE_TOTAL_EN
  localparam int unsigned TOT_W = CNT_W + IDX_W;

  logic [TOT_W-1:0] sum;

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < NUM_SIG; i++) begin
      sum = sum + TOT_W'(cnt[i]);
    end
  end

  assign res_total = res_last ? sum : '0;
`endif

endmodule

// File: tb/tb_toggle_activity_counter.sv
module tb_toggle_activity_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] window_len;
  logic [3:0]  sig_in;
  logic        res_ready;

  logic        busy, res_valid, res_last, done;
  logic [1:0]  res_idx;
  logic [15:0] res_count;
  logic        s_busy, s_res_valid, s_res_last, s_done;
  logic [1:0]  s_res_idx;
  logic [2:0]  s_res_count;
`ifdef TOGGLE_TOTAL_EN
  logic [17:0] res_total;
  logic [4:0]  s_res_total;
`endif

  always #5 clk = ~clk;

  toggle_activity_counter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .window_len(window_len),
    .sig_in    (sig_in),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_idx   (res_idx),
    .res_count (res_count),
    .res_last  (res_last),
`ifdef TOGGLE_TOTAL_EN
    .res_total (res_total),
`endif
    .done      (done)
  );

  // Narrow counters share all stimulus and exercise saturation.
  toggle_activity_counter #(
    .NUM_SIG(4),
    .CNT_W  (3),
    .WIN_W  (8)
  ) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .window_len(window_len[7:0]),
    .sig_in    (sig_in),
    .busy      (s_busy),
    .res_valid (s_res_valid),
    .res_ready (res_ready),
    .res_idx   (s_res_idx),
    .res_count (s_res_count),
    .res_last  (s_res_last),
`ifdef TOGGLE_TOTAL_EN
    .res_total (s_res_total),
`endif
    .done      (s_done)
  );

  typedef struct {
    int idx;
    int count;
    bit last;
    int total;
  } beat_t;

  beat_t       q_main[$];
  beat_t       q_sat[$];
  int          tests = 0;
  int          fails = 0;
  bit          hold_v[2];
  logic [17:0] hold_val[2];
  bit          exp_done[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor step for one DUT, evaluated at the falling edge.
  task automatic mon(input int w, input logic v, input logic [1:0] idx, input logic [15:0] cnt,
                     input logic last, input logic dn, input logic [17:0] tot);
    beat_t b;
    bit    have;
    if (exp_done[w] || dn) check($sformatf("done_pulse%0d", w), 64'(dn), 64'(exp_done[w]));
    exp_done[w] = 1'b0;
    if (hold_v[w]) check($sformatf("beat_held%0d", w), {v, idx, cnt}, {1'b1, hold_val[w]});
    hold_v[w]   = v && !res_ready;
    hold_val[w] = {idx, cnt};
    if (v && res_ready) begin
      have = (w == 0) ? (q_main.size() > 0) : (q_sat.size() > 0);
      if (!have) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat%0d: got beat idx %0d, expected none", w, idx);
      end else begin
        if (w == 0) b = q_main.pop_front();
        else b = q_sat.pop_front();
        check($sformatf("res_idx%0d", w), 64'(idx), 64'(b.idx));
        check($sformatf("res_count%0d_idx%0d", w, b.idx), 64'(cnt), 64'(b.count));
        check($sformatf("res_last%0d", w), 64'(last), 64'(b.last));
`ifdef TOGGLE_TOTAL_EN
        check($sformatf("res_total%0d", w), 64'(tot), 64'(b.total));
`else
        if (tot != 18'd0) check("res_total_absent", 64'(tot), 64'd0);
`endif
        if (last) exp_done[w] = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v   = '{default: 1'b0};
      exp_done = '{default: 1'b0};
    end else begin
`ifdef TOGGLE_TOTAL_EN
      mon(0, res_valid, res_idx, res_count, res_last, done, res_total);
      mon(1, s_res_valid, s_res_idx, 16'(s_res_count), s_res_last, s_done, 18'(s_res_total));
`else
      mon(0, res_valid, res_idx, res_count, res_last, done, 18'd0);
      mon(1, s_res_valid, s_res_idx, 16'(s_res_count), s_res_last, s_done, 18'd0);
`endif
    end
  end

  // One measurement. Entered and left at #1 after a rising edge with the DUT idle
  // (possibly in its done cycle, so back-to-back starts are exercised).
  // mode: 0 random, 1 bit0 toggles only, 2 mux2x1 {out,sel,b,a}, 3 all bits toggle.
  task automatic run(input int len, input int mode, input int stall, input bit abort);
    logic [3:0] v[$];
    logic [3:0] x;
    logic [3:0] cst;
    logic       a, b, s;
    int         c[4];
    int         tot_m, tot_s, sc;
    beat_t      bt;
    bit         got_done;
    cst = 4'($urandom);
    for (int k = 0; k <= len; k++) begin
      case (mode)
        1: x = {cst[3:1], k[0]};
        2: begin
          a = 1'($urandom);
          b = 1'($urandom);
          s = 1'($urandom);
          x = {s ? b : a, s, b, a};
        end
        3: x = k[0] ? 4'hF : 4'h0;
        default: begin
          if (k == 0 || $urandom_range(0, 1) == 1) x = 4'($urandom);
          else x = v[k-1];
        end
      endcase
      v.push_back(x);
    end
    for (int i = 0; i < 4; i++) begin
      c[i] = 0;
      for (int k = 1; k <= len; k++) if (v[k][i] != v[k-1][i]) c[i]++;
    end
    if (!abort) begin
      tot_m = 0;
      tot_s = 0;
      for (int i = 0; i < 4; i++) begin
        sc = (c[i] > 7) ? 7 : c[i];
        tot_m += c[i];
        tot_s += sc;
        bt = '{idx: i, count: c[i], last: (i == 3), total: (i == 3) ? tot_m : 0};
        q_main.push_back(bt);
        bt = '{idx: i, count: sc, last: (i == 3), total: (i == 3) ? tot_s : 0};
        q_sat.push_back(bt);
      end
    end

    start      = 1'b1;
    window_len = 16'(len);
    sig_in     = 4'($urandom);
    res_ready  = 1'($urandom);
    @(posedge clk); #1;
    start      = 1'b0;
    window_len = 16'($urandom);
    sig_in     = v[0];
    check("busy_after_start", {busy, s_busy}, 2'b11);
    for (int k = 1; k <= len; k++) begin
      @(posedge clk); #1;
      sig_in    = v[k];
      start     = ($urandom_range(0, 3) == 0);
      res_ready = 1'($urandom);
      if (abort && k == len / 2) begin
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs",
                 {busy, res_valid, res_idx, res_count, res_last, done,
                  s_busy, s_res_valid, s_res_idx, s_res_count, s_res_last, s_done}, 64'd0);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
    end
    check("no_early_valid", 64'(res_valid), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check($sformatf("first_valid_latency_len%0d", len), {res_valid, s_res_valid}, 2'b11);
    got_done = 1'b0;
    for (int cy = 0; cy < 200; cy++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      res_ready = (cy < stall) ? 1'b0 : ($urandom_range(0, 3) != 0);
      start     = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (got_done) begin
      check("idle_after_done", {busy, s_busy}, 2'b00);
    end else begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got no done within 200 cycles, expected done pulse");
      rst_n = 1'b0;
      q_main.delete();
      q_sat.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n      = 1'b1;
    start      = 1'b0;
    window_len = '0;
    sig_in     = '0;
    res_ready  = 1'b0;
    #3 rst_n = 1'b0;
    #10 check("reset_outputs",
              {busy, res_valid, res_idx, res_count, res_last, done,
               s_busy, s_res_valid, s_res_idx, s_res_count, s_res_last, s_done}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(8, 1, 0, 1'b0);    // bit0 toggles every cycle -> {8,0,0,0}
    run(7, 2, 0, 1'b0);    // mux2x1 vectors
    run(0, 0, 0, 1'b0);    // empty window
    run(20, 3, 0, 1'b0);   // saturation on the 3-bit instance
    run(12, 0, 5, 1'b0);   // consumer stalls at start of drain
    run(10, 0, 0, 1'b1);   // reset during counting
    run(8, 1, 0, 1'b0);    // clean result after reset
    for (int t = 0; t < 30; t++) begin
      run($urandom_range(0, 30), ($urandom_range(0, 3) == 0) ? 2 : 0,
          ($urandom_range(0, 3) == 0) ? 3 : 0, 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    repeat (3) @(posedge clk);
    #1 check("scoreboard_empty", 64'(q_main.size() + q_sat.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
